// File: rtl/apple2_ram_pkg.sv
// Shared types and defaults for the Apple II main-RAM arbiter.
// Holds the arbiter state encoding and the clear-sweep defaults.
package apple2_ram_pkg;

    localparam int RAM_AW = 18;

    typedef enum logic [1:0] {
        RST,
        CLEAR,
        IDLE,
        ACK
    } state_t;

    localparam logic [RAM_AW-1:0] DEF_CLR_BASE = 18'h00000;
    localparam logic [RAM_AW-1:0] DEF_CLR_LAST = 18'h3FFFF;
    localparam logic [7:0]        DEF_FILL     = 8'h00;

endpackage

// File: rtl/apple2_ram_arb.sv
// Main-RAM arbiter: clear sweep, core slot pass-through, host DMA.
// The sweep holds the CPU off until the configured range is filled.
module apple2_ram_arb
    import apple2_ram_pkg::*;
#(
    parameter logic [RAM_AW-1:0] CLR_BASE = DEF_CLR_BASE,
    parameter logic [RAM_AW-1:0] CLR_LAST = DEF_CLR_LAST,
    parameter logic [7:0]        FILL     = DEF_FILL
) (
    input  logic              CLK_14M,
    input  logic              RESET_N,
    input  logic              cold_start,
    input  logic              core_slot,
    input  logic              core_we,
    input  logic [RAM_AW-1:0] core_addr,
    input  logic [7:0]        core_di,
    input  logic              core_aux,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [RAM_AW-1:0] dma_addr,
    input  logic [7:0]        dma_di,
    input  logic              dma_aux,
    output logic              dma_ack,
    output logic [7:0]        dma_do,
    output logic              core_hold,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [7:0]        ram_di,
    output logic              ram_aux,
    input  logic [15:0]       ram_do
);

    state_t            state;
    state_t            state_nx;
    logic [RAM_AW-1:0] clr_addr;
    logic [RAM_AW-1:0] clr_addr_nx;
    logic              aux_q;
    logic              aux_nx;
    logic              we_q;
    logic              we_nx;
    logic [7:0]        do_q;
    logic [7:0]        do_nx;
    logic [7:0]        rd_byte;

    // Bank select for DMA read data, using the bank latched at grant.
    assign rd_byte = aux_q ? ram_do[15:8] : ram_do[7:0];

    // State, sweep pointer, latched DMA attributes and read-data holder.
    always_ff @(posedge CLK_14M or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= RST;
            clr_addr <= CLR_BASE;
            aux_q    <= 1'b0;
            we_q     <= 1'b0;
            do_q     <= 8'h00;
        end else begin
            state    <= state_nx;
            clr_addr <= clr_addr_nx;
            aux_q    <= aux_nx;
            we_q     <= we_nx;
            do_q     <= do_nx;
        end
    end

    // Next-state logic and the RAM output mux.
    always_comb begin
        state_nx    = state;
        clr_addr_nx = clr_addr;
        aux_nx      = aux_q;
        we_nx       = we_q;
        do_nx       = do_q;
        ram_we      = 1'b0;
        ram_addr    = core_addr;
        ram_di      = core_di;
        ram_aux     = core_aux;
        core_hold   = 1'b0;
        dma_ack     = 1'b0;
        dma_do      = do_q;
        unique case (state)
            RST: begin
                core_hold   = 1'b1;
                clr_addr_nx = CLR_BASE;
                state_nx    = CLEAR;
            end
            CLEAR: begin
                core_hold = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = clr_addr;
                ram_di    = FILL;
                ram_aux   = 1'b0;
                if (cold_start) begin
                    clr_addr_nx = CLR_BASE;
                end else if (clr_addr == CLR_LAST) begin
                    state_nx = IDLE;
                end else begin
                    clr_addr_nx = clr_addr + 18'd1;
                end
            end
            IDLE: begin
                // A grant is suppressed when a sweep is about to start,
                // since its ACK would never be delivered.
                if (core_slot) begin
                    ram_we = core_we;
                end else if (dma_req && !cold_start) begin
                    ram_we   = dma_we;
                    ram_addr = dma_addr;
                    ram_di   = dma_di;
                    ram_aux  = dma_aux;
                    aux_nx   = dma_aux;
                    we_nx    = dma_we;
                    state_nx = ACK;
                end
                if (cold_start) begin
                    state_nx    = CLEAR;
                    clr_addr_nx = CLR_BASE;
                end
            end
            ACK: begin
                dma_ack = 1'b1;
                if (!we_q) begin
                    dma_do = rd_byte;
                    do_nx  = rd_byte;
                end
                if (core_slot) begin
                    ram_we = core_we;
                end
                state_nx = IDLE;
                if (cold_start) begin
                    state_nx    = CLEAR;
                    clr_addr_nx = CLR_BASE;
                end
            end
            default: begin
                state_nx = RST;
            end
        endcase
    end

endmodule
